// File: rtl/vga_plane_writer.sv
// vga_plane_writer: expands each captured CPU write into one SRAM write per plane enabled in the map mask.
module vga_plane_writer #(
    parameter int NPL = 4,
    parameter int DW = 16,
    parameter int AW = 16,
    localparam int PW = $clog2(NPL),
    localparam int NB = DW / 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [AW:1]         wbs_adr_i,
    input  logic [NB-1:0]       wbs_sel_i,
    input  logic [DW-1:0]       wbs_dat_i,
    input  logic                wbs_stb_i,
    output logic                wbs_ack_o,
    output logic [PW+AW-1:1]    wbm_adr_o,
    output logic [NB-1:0]       wbm_sel_o,
    output logic [DW-1:0]       wbm_dat_o,
    output logic                wbm_stb_o,
    input  logic                wbm_ack_i,
    output logic                busy_o,
    input  logic                memory_mapping1,
    input  logic [1:0]          write_mode,
    input  logic [1:0]          raster_op,
    input  logic [2:0]          rotate_count,
    input  logic [7:0]          bitmask,
    input  logic [NPL-1:0]      set_reset,
    input  logic [NPL-1:0]      enable_set_reset,
    input  logic [NPL-1:0]      map_mask,
    input  logic [8*NPL-1:0]    latch
);
    typedef enum logic [1:0] {IDLE, WRITE, ACK} state_t;
    state_t state;
    logic [AW:1] adr_q;
    logic [NB-1:0] sel_q;
    logic [DW-1:0] dat_q;
    logic mm1_q;
    logic [1:0] mode_q, rop_q;
    logic [2:0] rot_q;
    logic [7:0] bm_q;
    logic [NPL-1:0] sr_q, esr_q, pending, pending_n;
    logic [8*NPL-1:0] latch_q;
    logic [PW-1:0] plane;
    logic [7:0] lat, c, d, s, e, a;

    function automatic logic [PW-1:0] lowest(input logic [NPL-1:0] v);
        lowest = '0;
        for (int i = NPL - 1; i >= 0; i--)
            if (v[i]) lowest = PW'(i);
    endfunction

    assign pending_n = pending & ~(NPL'(1) << plane);
    assign wbs_ack_o = state == ACK;
    assign wbm_stb_o = state == WRITE;
    assign busy_o = state != IDLE;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = {plane, adr_q[AW-1] & ~mm1_q, adr_q[AW-2:1]};

    always_comb begin
        wbm_dat_o = '0;
        lat = latch_q[8*plane +: 8];
        c = '0;
        d = '0;
        s = '0;
        e = '0;
        a = '0;
        for (int b = 0; b < NB; b++) begin
            c = dat_q[8*b +: 8];
            d = 8'({c, c} >> rot_q);
            s = mode_q == 2'd0 ? (esr_q[plane] ? {8{sr_q[plane]}} : d) :
                mode_q == 2'd2 ? {8{c[plane]}} : {8{sr_q[plane]}};
            e = mode_q == 2'd3 ? bm_q & d : bm_q;
            a = rop_q == 2'd0 ? s : rop_q == 2'd1 ? s & lat : rop_q == 2'd2 ? s | lat : s ^ lat;
            wbm_dat_o[8*b +: 8] = mode_q == 2'd1 ? lat : (a & e) | (lat & ~e);
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
            adr_q <= '0;
            sel_q <= '0;
            dat_q <= '0;
            mm1_q <= 1'b0;
            mode_q <= '0;
            rop_q <= '0;
            rot_q <= '0;
            bm_q <= '0;
            sr_q <= '0;
            esr_q <= '0;
            latch_q <= '0;
            pending <= '0;
            plane <= '0;
        end else begin
            case (state)
                IDLE: if (wbs_stb_i) begin
                    adr_q <= wbs_adr_i;
                    sel_q <= wbs_sel_i;
                    dat_q <= wbs_dat_i;
                    mm1_q <= memory_mapping1;
                    mode_q <= write_mode;
                    rop_q <= raster_op;
                    rot_q <= rotate_count;
                    bm_q <= bitmask;
                    sr_q <= set_reset;
                    esr_q <= enable_set_reset;
                    latch_q <= latch;
                    pending <= map_mask;
                    plane <= lowest(map_mask);
                    state <= |map_mask ? WRITE : ACK;
                end
                // A dropped CPU strobe abandons the remaining planes silently.
                WRITE: if (!wbs_stb_i) state <= IDLE;
                    else if (wbm_ack_i) begin
                        pending <= pending_n;
                        plane <= lowest(pending_n);
                        if (pending_n == '0) state <= ACK;
                    end
                ACK: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_plane_writer.sv
// tb_vga_plane_writer: scoreboard bench; expected SRAM writes are queued at request time and popped on each SRAM ack.
module tb_vga_plane_writer;
    localparam int NPL = 4, DW = 16, AW = 16, PW = 2, NB = 2;
    typedef struct packed {logic [16:0] adr; logic [15:0] dat; logic [1:0] sel;} exp_t;

    logic clk = 0, rst = 1;
    logic [AW:1] wbs_adr_i = '0;
    logic [NB-1:0] wbs_sel_i = '0;
    logic [DW-1:0] wbs_dat_i = '0;
    logic wbs_stb_i = 0, wbs_ack_o;
    logic [PW+AW-1:1] wbm_adr_o;
    logic [NB-1:0] wbm_sel_o;
    logic [DW-1:0] wbm_dat_o;
    logic wbm_stb_o, wbm_ack_i, busy_o;
    logic memory_mapping1 = 0;
    logic [1:0] write_mode = 0, raster_op = 0;
    logic [2:0] rotate_count = 0;
    logic [7:0] bitmask = 0;
    logic [NPL-1:0] set_reset = 0, enable_set_reset = 0, map_mask = 0;
    logic [8*NPL-1:0] latch = 0;
    int checks = 0, errors = 0, waits = 0, cnt = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    vga_plane_writer #(.NPL(NPL), .DW(DW), .AW(AW)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wbs_adr_i(wbs_adr_i), .wbs_sel_i(wbs_sel_i),
        .wbs_dat_i(wbs_dat_i), .wbs_stb_i(wbs_stb_i), .wbs_ack_o(wbs_ack_o),
        .wbm_adr_o(wbm_adr_o), .wbm_sel_o(wbm_sel_o), .wbm_dat_o(wbm_dat_o),
        .wbm_stb_o(wbm_stb_o), .wbm_ack_i(wbm_ack_i), .busy_o(busy_o),
        .memory_mapping1(memory_mapping1), .write_mode(write_mode), .raster_op(raster_op),
        .rotate_count(rotate_count), .bitmask(bitmask), .set_reset(set_reset),
        .enable_set_reset(enable_set_reset), .map_mask(map_mask), .latch(latch)
    );

    // SRAM slave model with a programmable number of wait states per plane.
    assign wbm_ack_i = wbm_stb_o && cnt >= waits;
    always @(posedge clk) cnt <= (wbm_stb_o && !wbm_ack_i) ? cnt + 1 : 0;

    initial begin : monitor
        exp_t e, p;
        bit in_wait = 0;
        p = '0;
        forever begin
            @(negedge clk);
            if (wbm_stb_o && wbm_ack_i) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL sram_write unexpected adr=%h dat=%h sel=%h", wbm_adr_o, wbm_dat_o, wbm_sel_o);
                end else begin
                    e = q.pop_front();
                    if ({17'(wbm_adr_o), wbm_dat_o, wbm_sel_o} !== {e.adr, e.dat, e.sel}) begin
                        errors++;
                        $display("FAIL sram_write got adr=%h dat=%h sel=%h exp adr=%h dat=%h sel=%h",
                                 wbm_adr_o, wbm_dat_o, wbm_sel_o, e.adr, e.dat, e.sel);
                    end
                end
            end
            if (wbm_stb_o && !wbm_ack_i) begin
                if (in_wait) begin
                    checks++;
                    if ({17'(wbm_adr_o), wbm_dat_o, wbm_sel_o} !== {p.adr, p.dat, p.sel}) begin
                        errors++;
                        $display("FAIL wait_stable got adr=%h dat=%h sel=%h exp adr=%h dat=%h sel=%h",
                                 wbm_adr_o, wbm_dat_o, wbm_sel_o, p.adr, p.dat, p.sel);
                    end
                end
                in_wait = 1;
                p = {17'(wbm_adr_o), wbm_dat_o, wbm_sel_o};
            end else in_wait = 0;
        end
    end

    task automatic push(input int p, input logic [14:0] off, input logic [15:0] dat, input logic [1:0] sel);
        q.push_back({2'(p), off, dat, sel});
    endtask

    task automatic set_cfg(input logic [1:0] mode, rop, input logic [2:0] rot, input logic [7:0] bm,
                           input logic [3:0] sr, esr, mm, input logic [31:0] lat, input logic mm1);
        write_mode = mode; raster_op = rop; rotate_count = rot; bitmask = bm;
        set_reset = sr; enable_set_reset = esr; map_mask = mm; latch = lat; memory_mapping1 = mm1;
    endtask

    task automatic scramble();
        set_cfg(2'($urandom), 2'($urandom), 3'($urandom), 8'($urandom), 4'($urandom),
                4'($urandom), 4'($urandom), $urandom, 1'($urandom));
        wbs_adr_i = 16'($urandom); wbs_dat_i = 16'($urandom); wbs_sel_i = 2'($urandom);
    endtask

    task automatic do_req(input string name, input logic [15:0] a, input logic [1:0] sel,
                          input logic [15:0] dat, input int exp_cyc);
        int got = -1;
        @(negedge clk);
        wbs_adr_i = a; wbs_sel_i = sel; wbs_dat_i = dat; wbs_stb_i = 1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk); #1;
            if (c == 1) scramble();
            if (wbs_ack_o) begin got = c; break; end
        end
        wbs_stb_i = 0;
        checks++;
        if (got !== exp_cyc) begin
            errors++;
            $display("FAIL %s ack_cycle got %0d exp %0d", name, got, exp_cyc);
        end
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL %s missing_writes got %0d left exp 0", name, q.size());
        end
        q.delete();
    endtask

    function automatic logic [15:0] model(input int p, input logic [1:0] mode, rop, input logic [2:0] rot,
                                          input logic [7:0] bm, input logic [3:0] sr, esr,
                                          input logic [31:0] lat, input logic [15:0] d);
        logic [7:0] r, rr, l, s, m, a;
        for (int b = 0; b < 2; b++) begin
            r = d[8*b +: 8];
            rr = (r >> rot) | (r << (8 - rot));
            l = lat[8*p +: 8];
            s = 0; m = 0;
            case (mode)
                2'd0: begin s = esr[p] ? {8{sr[p]}} : rr; m = bm; end
                2'd2: begin s = {8{r[p]}}; m = bm; end
                2'd3: begin s = {8{sr[p]}}; m = bm & rr; end
                default: ;
            endcase
            case (rop)
                2'd0: a = s;
                2'd1: a = s & l;
                2'd2: a = s | l;
                default: a = s ^ l;
            endcase
            model[8*b +: 8] = mode == 2'd1 ? l : (a & m) | (l & ~m);
        end
    endfunction

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({wbs_ack_o, wbm_stb_o, busy_o, wbm_adr_o, wbm_dat_o, wbm_sel_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got ack=%b stb=%b busy=%b adr=%h dat=%h sel=%h exp all 0",
                     wbs_ack_o, wbm_stb_o, busy_o, wbm_adr_o, wbm_dat_o, wbm_sel_o);
        end
        rst = 0;
    endtask

    task automatic test_basic();
        set_cfg(0, 0, 0, 8'hFF, 0, 0, 4'b0101, 32'hA5A5A5A5, 0);
        push(0, 15'h0246, 16'h1234, 2'b11);
        push(2, 15'h0246, 16'h1234, 2'b11);
        do_req("basic", 16'h0246, 2'b11, 16'h1234, 3);
    endtask

    task automatic test_modes();
        set_cfg(2, 0, 0, 8'h0F, 0, 0, 4'b0001, 32'h123456F0, 0);
        push(0, 15'h0010, 16'hF0FF, 2'b01);
        do_req("mode2", 16'h0010, 2'b01, 16'h0A05, 2);
        set_cfg(3, 0, 0, 8'hF0, 4'b0001, 0, 4'b0001, 32'h77777700, 0);
        push(0, 15'h0011, 16'h3030, 2'b11);
        do_req("mode3", 16'h0011, 2'b11, 16'h3C3C, 2);
        set_cfg(0, 0, 4, 8'hFF, 0, 0, 4'b0001, 32'h0, 0);
        push(0, 15'h0012, 16'h0021, 2'b11);
        do_req("rotate", 16'h0012, 2'b11, 16'h0012, 2);
        set_cfg(0, 3, 4, 8'hFF, 0, 0, 4'b0001, 32'h000000FF, 0);
        push(0, 15'h0013, 16'hFFDE, 2'b11);
        do_req("rotate_xor", 16'h0013, 2'b11, 16'h0012, 2);
    endtask

    task automatic test_nomask_mm1();
        set_cfg(0, 0, 0, 8'hFF, 0, 0, 4'b0000, 32'h0, 0);
        do_req("no_planes", 16'h1234, 2'b11, 16'hBEEF, 1);
        set_cfg(0, 0, 0, 8'hFF, 0, 0, 4'b0001, 32'h0, 1);
        push(0, 15'h3FFF, 16'h5566, 2'b10);
        do_req("mm1", 16'hFFFF, 2'b10, 16'h5566, 2);
        set_cfg(0, 0, 0, 8'hFF, 0, 0, 4'b1000, 32'h0, 0);
        push(3, 15'h7FFF, 16'h5566, 2'b10);
        do_req("mm0", 16'hFFFF, 2'b10, 16'h5566, 2);
    endtask

    task automatic test_wait_states();
        waits = 2;
        set_cfg(0, 2, 1, 8'h3C, 4'b1010, 4'b0110, 4'b1111, 32'h0F1E2D3C, 0);
        for (int p = 0; p < 4; p++) push(p, 15'h0100, model(p, 0, 2, 1, 8'h3C, 4'b1010, 4'b0110, 32'h0F1E2D3C, 16'h9A6B), 2'b11);
        do_req("wait_states", 16'h0100, 2'b11, 16'h9A6B, 13);
        waits = 0;
    endtask

    task automatic test_reset_mid();
        int found = 0;
        waits = 3;
        set_cfg(0, 0, 0, 8'hFF, 0, 0, 4'b0011, 32'h0, 0);
        push(0, 15'h0200, 16'hC0DE, 2'b11);
        push(1, 15'h0200, 16'hC0DE, 2'b11);
        @(negedge clk);
        wbs_adr_i = 16'h0200; wbs_sel_i = 2'b11; wbs_dat_i = 16'hC0DE; wbs_stb_i = 1;
        for (int c = 1; c <= 50; c++) begin
            @(posedge clk); #1;
            if (wbm_stb_o && wbm_adr_o[17:16] == 2'd1) begin found = 1; break; end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL reset_mid plane1_reached got 0 exp 1"); end
        rst = 1; wbs_stb_i = 0;
        @(posedge clk); #1;
        checks++;
        if ({wbs_ack_o, wbm_stb_o, busy_o, wbm_adr_o, wbm_dat_o, wbm_sel_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs got ack=%b stb=%b busy=%b adr=%h dat=%h sel=%h exp all 0",
                     wbs_ack_o, wbm_stb_o, busy_o, wbm_adr_o, wbm_dat_o, wbm_sel_o);
        end
        rst = 0;
        q.delete();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++;
            if (wbs_ack_o || busy_o) begin
                errors++;
                $display("FAIL reset_mid_quiet got ack=%b busy=%b exp 0 0", wbs_ack_o, busy_o);
            end
        end
        set_cfg(0, 0, 0, 8'hFF, 0, 0, 4'b0001, 32'h0, 0);
        push(0, 15'h0201, 16'h4321, 2'b01);
        do_req("after_reset", 16'h0201, 2'b01, 16'h4321, 5);
        waits = 0;
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int acks[2] = '{-1, -1};
        set_cfg(0, 0, 0, 8'hFF, 0, 0, 4'b0001, 32'h0, 0);
        push(0, 15'h0300, 16'h0F0F, 2'b11);
        push(0, 15'h0300, 16'h0F0F, 2'b11);
        @(negedge clk);
        wbs_adr_i = 16'h0300; wbs_sel_i = 2'b11; wbs_dat_i = 16'h0F0F; wbs_stb_i = 1;
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (wbs_ack_o) begin acks[n] = c; n++; if (n == 2) break; end
        end
        wbs_stb_i = 0;
        checks++;
        if (acks[0] !== 2 || acks[1] !== 5) begin
            errors++;
            $display("FAIL back_to_back ack_cycles got %0d,%0d exp 2,5", acks[0], acks[1]);
        end
        @(negedge clk);
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL back_to_back missing_writes got %0d exp 0", q.size()); end
        q.delete();
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            logic [1:0] mode = 2'($urandom), rop = 2'($urandom), sel = 2'($urandom);
            logic [2:0] rot = 3'($urandom);
            logic [7:0] bm = 8'($urandom);
            logic [3:0] sr = 4'($urandom), esr = 4'($urandom), mm = 4'($urandom);
            logic [31:0] lat = $urandom;
            logic mm1 = 1'($urandom);
            logic [15:0] a = 16'($urandom), d = 16'($urandom);
            int k = 0;
            waits = $urandom_range(0, 2);
            set_cfg(mode, rop, rot, bm, sr, esr, mm, lat, mm1);
            for (int p = 0; p < 4; p++)
                if (mm[p]) begin
                    push(p, {a[14] & ~mm1, a[13:0]}, model(p, mode, rop, rot, bm, sr, esr, lat, d), sel);
                    k++;
                end
            do_req("random", a, sel, d, k == 0 ? 1 : k * (waits + 1) + 1);
        end
        waits = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_modes();
        test_nomask_mm1();
        test_wait_states();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
